data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of WIDTH-bit words stored.
REQ-003 The block SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1, active-low reset; its assertion is asynchronous.
REQ-006 The block SHALL have port mem_req_i, input, 1, request valid from the cache.
REQ-007 The block SHALL have port mem_address_i, input, WIDTH, byte address.
REQ-008 The block SHALL have port mem_write_data_i, input, WIDTH, store data; byte stores use bits [7:0].
REQ-009 The block SHALL have port mem_write_enable_i, input, 1, 1 = store, 0 = load.
REQ-010 The block SHALL have port mem_byte_op_i, input, 1, 1 = byte access, 0 = word access.
REQ-011 The block SHALL have port mem_read_data_o, output, WIDTH, load response data.
REQ-012 The block SHALL have port mem_ready_o, output, 1, one-cycle response strobe.
REQ-013 The block SHALL have port mem_busy_o, output, 1, high when a request is in flight and no new request can be accepted.
REQ-014 The block SHALL have port mem_error_o, output, 1, out-of-range flag, valid only while mem_ready_o is high.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 A request SHALL be accepted on a rising edge where mem_req_i=1 and the state is IDLE or RESP; address, data, write enable and byte op are registered on that edge.
REQ-017 When LATENCY>1, acceptance SHALL move the FSM to WAIT and load the down-counter with LATENCY-2; WAIT SHALL move to RESP on the edge where the counter is 0.
REQ-018 When LATENCY=1, acceptance SHALL move the FSM directly to RESP.
REQ-019 mem_ready_o SHALL be high exactly LATENCY cycles after the accepting edge, for exactly one cycle (state RESP).
REQ-020 mem_busy_o SHALL be high in the WAIT state and low in the IDLE and RESP states.
REQ-021 mem_req_i in WAIT SHALL be ignored; the initiator holds it until it is accepted.
REQ-022 RESP with mem_req_i=1 SHALL accept the next request on the same edge (back-to-back operation); RESP with mem_req_i=0 SHALL return to IDLE.
REQ-023 The word index SHALL be address[WIDTH-1:2]; address[1:0] SHALL select the byte lane for byte operations and SHALL be ignored for word operations.
REQ-024 A word store SHALL write all 32 bits on the edge entering RESP.
REQ-025 A byte store SHALL write only lane address[1:0] (lane 0 = [7:0] ... lane 3 = [31:24]) with write_data[7:0]; all other lanes are unchanged.
REQ-026 A word load SHALL drive the stored word on mem_read_data_o during RESP.
REQ-027 A byte load SHALL drive the selected lane zero-extended to 32 bits.
REQ-028 mem_read_data_o SHALL hold its last value outside RESP; a store response SHALL leave it unchanged.
REQ-029 A word index >= DEPTH SHALL raise mem_error_o together with mem_ready_o, suppress the write, and return 0 on a load.
REQ-030 Contents SHALL be zero at time 0; a read in the same RESP as a write to the same word is impossible because only one request is in flight.

Reset
REQ-031 While rst_ni=0, the FSM SHALL be IDLE, the counter 0, and mem_ready_o, mem_busy_o, mem_error_o and mem_read_data_o all 0.
REQ-032 Reset asserted mid-request SHALL abort the request with no write and no response strobe.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 The first acceptance after reset SHALL be possible on the first rising edge after rst_ni deasserts.

Structure
REQ-035 Package mem_pkg SHALL hold the state enum, the lane constants and the default LATENCY and DEPTH values.
REQ-036 Storage SHALL be the sub-module mem_array, a single-port array with a 4-bit byte-enable write and a combinational read.
REQ-037 The FSM, latency counter and response register SHALL reside in data_mem_responder.

Verification
REQ-038 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> ready 2 cycles after each acceptance, read data 0xDEADBEEF, error 0.
REQ-039 Byte store 0xA5 to 0x11 over 0xDEADBEEF, then word load 0x10 -> 0xDEADA5EF; byte load 0x13 -> 0x000000DE.
REQ-040 Request held through WAIT, then back-to-back loads of 0x0 and 0x4 with mem_req_i high in RESP -> ready pulses 2 cycles apart, busy never high in RESP.
REQ-041 With LATENCY=1, a load accepted at edge N -> ready at N+1, busy never asserted.
REQ-042 Load 0x1000 with DEPTH=1024 -> ready with error=1, data 0; a store to 0x1000 leaves word 0 unchanged.
REQ-043 Store accepted, then rst_ni pulled low during WAIT -> no ready pulse, target word unchanged, all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

    localparam int DEFAULT_DEPTH   = 1024;
    localparam int DEFAULT_LATENCY = 2;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] lane);
        return NUM_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Cache-to-memory request/response bundle; the responder uses the slave view.
interface data_mem_responder_if #(
    parameter int WIDTH = 32
);

    logic             mem_req_i;
    logic [WIDTH-1:0] mem_address_i;
    logic [WIDTH-1:0] mem_write_data_i;
    logic             mem_write_enable_i;
    logic             mem_byte_op_i;
    logic [WIDTH-1:0] mem_read_data_o;
    logic             mem_ready_o;
    logic             mem_busy_o;
    logic             mem_error_o;

    modport slave (
        input  mem_req_i,
        input  mem_address_i,
        input  mem_write_data_i,
        input  mem_write_enable_i,
        input  mem_byte_op_i,
        output mem_read_data_o,
        output mem_ready_o,
        output mem_busy_o,
        output mem_error_o
    );

    modport master (
        output mem_req_i,
        output mem_address_i,
        output mem_write_data_i,
        output mem_write_enable_i,
        output mem_byte_op_i,
        input  mem_read_data_o,
        input  mem_ready_o,
        input  mem_busy_o,
        input  mem_error_o
    );

endinterface

// File: rtl/mem_array.sv
// Single-port word storage with per-byte write enables and combinational read.
module mem_array
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [NUM_LANES-1:0] be_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] words [DEPTH];

    // Storage is deliberately not reset so contents survive a responder reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (be_i[l]) begin
                    words[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata_o = words[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: accepts one request at a time and
// answers with a single-cycle ready strobe LATENCY cycles after acceptance.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    data_mem_responder_if.slave bus
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit         DIRECT   = (LATENCY == 1);
    localparam logic [3:0] LAT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             byte_q, byte_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic                 accept;
    logic                 enter_resp;
    logic [WIDTH-1:0]     op_addr;
    logic [WIDTH-1:0]     op_wdata;
    logic                 op_we;
    logic                 op_byte;
    logic [WIDTH-1:0]     word_idx;
    logic                 in_range;
    logic [1:0]           lane;
    logic [NUM_LANES-1:0] arr_be;
    logic [WIDTH-1:0]     arr_wdata;
    logic [WIDTH-1:0]     arr_rdata;
    logic                 arr_we;
    logic [LANE_W-1:0]    lane_byte;
    logic [WIDTH-1:0]     load_data;

    assign accept = bus.mem_req_i && ((state_q == IDLE) || (state_q == RESP));

    // With a one-cycle latency the response edge is the acceptance edge itself,
    // so the operation has to come straight from the bus instead of the capture.
    assign enter_resp = DIRECT ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));
    assign op_addr    = DIRECT ? bus.mem_address_i      : addr_q;
    assign op_wdata   = DIRECT ? bus.mem_write_data_i   : wdata_q;
    assign op_we      = DIRECT ? bus.mem_write_enable_i : we_q;
    assign op_byte    = DIRECT ? bus.mem_byte_op_i      : byte_q;

    assign word_idx  = {2'b00, op_addr[WIDTH-1:2]};
    assign in_range  = word_idx < WIDTH'(DEPTH);
    assign lane      = op_addr[1:0];
    assign arr_be    = op_byte ? lane_mask(lane) : '1;
    assign arr_wdata = op_byte ? {NUM_LANES{op_wdata[LANE_W-1:0]}} : op_wdata;
    assign arr_we    = enter_resp && op_we && in_range && rst_ni;

    mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .addr_i  (word_idx[AW-1:0]),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        lane_byte = arr_rdata[7:0];
        unique case (lane)
            LANE0: lane_byte = arr_rdata[7:0];
            LANE1: lane_byte = arr_rdata[15:8];
            LANE2: lane_byte = arr_rdata[23:16];
            LANE3: lane_byte = arr_rdata[31:24];
            default: lane_byte = arr_rdata[7:0];
        endcase
        load_data = op_byte ? {{(WIDTH-LANE_W){1'b0}}, lane_byte} : arr_rdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        byte_d  = byte_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE, RESP: begin
                if (bus.mem_req_i) begin
                    addr_d  = bus.mem_address_i;
                    wdata_d = bus.mem_write_data_i;
                    we_d    = bus.mem_write_enable_i;
                    byte_d  = bus.mem_byte_op_i;
                    if (DIRECT) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stores leave the read data register alone; out-of-range loads return zero.
        if (enter_resp) begin
            err_d = !in_range;
            if (!op_we) begin
                rdata_d = in_range ? load_data : '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_ready_o     = (state_q == RESP);
    assign bus.mem_busy_o      = (state_q == WAIT);
    assign bus.mem_error_o     = (state_q == RESP) && err_q;
    assign bus.mem_read_data_o = rdata_q;

endmodule
